// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that assembles a little-endian byte stream
// into 32-bit words, writes them to instruction memory at consecutive word
// addresses, verifies an XOR checksum and holds the core in reset until a
// load completes cleanly.
module imem_loader #(
    parameter int Width = 32,
    parameter int Depth = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             we,
    output logic [Width-1:0] waddr,
    output logic [Width-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             cpu_hold,
    output logic [7:0]       wcount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [8:0] DEPTH_LIM = 9'(Depth);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_len;
    logic [1:0]       r_byte_idx;
    logic [7:0]       r_word_idx;
    logic [7:0]       r_wcount;
    logic [7:0]       r_csum;
    logic [23:0]      r_shift;
    logic             r_we;
    logic [Width-1:0] r_waddr;
    logic [Width-1:0] r_wdata;

    logic w_xfer;
    logic w_start_ok;
    logic w_len_bad;
    logic w_last_word;

    assign w_xfer      = byte_valid && byte_ready;
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign w_len_bad   = (byte_data == 8'd0) || ({1'b0, byte_data} > DEPTH_LIM);
    assign w_last_word = (r_byte_idx == 2'd3) && (8'(r_word_idx + 8'd1) == r_len);

    assign we     = r_we;
    assign waddr  = r_waddr;
    assign wdata  = r_wdata;
    assign wcount = r_wcount;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_next = S_LEN;
            end
            S_LEN: begin
                if (w_xfer) w_next = w_len_bad ? S_ERR : S_DATA;
            end
            S_DATA: begin
                if (w_xfer && w_last_word) w_next = S_CSUM;
            end
            S_CSUM: begin
                if (w_xfer) w_next = (byte_data == r_csum) ? S_DONE : S_ERR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs, decoded from state only
    always_comb begin
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        cpu_hold   = 1'b1;
        case (r_state)
            S_LEN, S_DATA, S_CSUM: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: length latch, word assembly, checksum and write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_byte_idx <= '0;
            r_word_idx <= '0;
            r_wcount   <= '0;
            r_csum     <= '0;
            r_shift    <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_start_ok) begin
                r_byte_idx <= '0;
                r_word_idx <= '0;
                r_wcount   <= '0;
                r_csum     <= '0;
            end
            if (w_xfer && (r_state == S_LEN)) begin
                r_len <= byte_data;
            end
            if (w_xfer && (r_state == S_DATA)) begin
                r_csum     <= r_csum ^ byte_data;
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0:    r_shift[7:0]   <= byte_data;
                    2'd1:    r_shift[15:8]  <= byte_data;
                    2'd2:    r_shift[23:16] <= byte_data;
                    default: begin
                        // Lane 3 goes straight into the write register.
                        r_we       <= 1'b1;
                        r_waddr    <= Width'({r_word_idx, 2'b00});
                        r_wdata    <= Width'({byte_data, r_shift});
                        r_word_idx <= r_word_idx + 8'd1;
                        r_wcount   <= r_wcount + 8'd1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a per-cycle vector table for the
// nominal load, then directed sequences for error, flow-control, reset and
// full-depth reload cases.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_hold;
    logic [7:0]  wcount;

    int total = 0;
    int bad = 0;

    imem_loader #(.Width(32), .Depth(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_hold   (cpu_hold),
        .wcount     (wcount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t wq[$];

    // Record every write strobe, sampled mid-cycle
    always @(negedge clk) begin
        if (we) wq.push_back('{a: waddr, d: wdata});
    end

    typedef struct {
        logic        st;
        logic        bv;
        logic [7:0]  bd;
        logic        e_rdy;
        logic        e_we;
        logic [31:0] e_a;
        logic [31:0] e_d;
        logic        e_dn;
        logic        e_er;
        logic        e_h;
        logic [7:0]  e_wc;
    } vec_t;

    vec_t        tbl[13];
    logic [31:0] tx[64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ready"}, 32'(byte_ready), 32'd0);
        chk({tag, ".we"}, 32'(we), 32'd0);
        chk({tag, ".waddr"}, waddr, 32'd0);
        chk({tag, ".wdata"}, wdata, 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".err"}, 32'(err), 32'd0);
        chk({tag, ".hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, ".wcount"}, 32'(wcount), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int maxgap);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        repeat (g) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
    endtask

    task automatic idle_bus();
        @(negedge clk);
        byte_valid = 1'b0;
        #1;
    endtask

    // Stream n words from tx[] followed by csum; the length byte is n
    task automatic stream(input int n, input logic [7:0] csum, input int maxgap);
        send(8'(n), maxgap);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                send(tx[w][k*8 +: 8], maxgap);
            end
        end
        send(csum, maxgap);
        idle_bus();
    endtask

    function automatic logic [7:0] xor_of(input int n);
        logic [7:0] x;
        x = 8'h00;
        for (int w = 0; w < n; w++) x = x ^ tx[w][7:0] ^ tx[w][15:8] ^ tx[w][23:16] ^ tx[w][31:24];
        return x;
    endfunction

    function automatic vec_t mk(input logic st, input logic bv, input logic [7:0] bd,
                                input logic rdy, input logic wev, input logic [31:0] a,
                                input logic [31:0] d, input logic dn, input logic er,
                                input logic h, input logic [7:0] wc);
        vec_t v;
        v.st = st; v.bv = bv; v.bd = bd; v.e_rdy = rdy; v.e_we = wev; v.e_a = a;
        v.e_d = d; v.e_dn = dn; v.e_er = er; v.e_h = h; v.e_wc = wc;
        return v;
    endfunction

    initial begin
        // Nominal load, one row per cycle. Outputs are checked in the same
        // cycle the row's inputs are driven. Checksum of the eight data
        // bytes 13 05 00 00 93 02 A0 00 is 0x27.
        tbl[0]  = mk(1, 0, 8'h00, 0, 0, 32'h0, 32'h0,        0, 0, 1, 8'd0);
        tbl[1]  = mk(0, 1, 8'h02, 1, 0, 32'h0, 32'h0,        0, 0, 1, 8'd0);
        tbl[2]  = mk(0, 1, 8'h13, 1, 0, 32'h0, 32'h0,        0, 0, 1, 8'd0);
        tbl[3]  = mk(0, 1, 8'h05, 1, 0, 32'h0, 32'h0,        0, 0, 1, 8'd0);
        tbl[4]  = mk(0, 1, 8'h00, 1, 0, 32'h0, 32'h0,        0, 0, 1, 8'd0);
        tbl[5]  = mk(0, 1, 8'h00, 1, 0, 32'h0, 32'h0,        0, 0, 1, 8'd0);
        tbl[6]  = mk(0, 1, 8'h93, 1, 1, 32'h0, 32'h00000513, 0, 0, 1, 8'd1);
        tbl[7]  = mk(0, 1, 8'h02, 1, 0, 32'h0, 32'h00000513, 0, 0, 1, 8'd1);
        tbl[8]  = mk(0, 1, 8'hA0, 1, 0, 32'h0, 32'h00000513, 0, 0, 1, 8'd1);
        tbl[9]  = mk(0, 1, 8'h00, 1, 0, 32'h0, 32'h00000513, 0, 0, 1, 8'd1);
        tbl[10] = mk(0, 1, 8'h27, 1, 1, 32'h4, 32'h00A00293, 0, 0, 1, 8'd2);
        tbl[11] = mk(0, 0, 8'h00, 0, 0, 32'h4, 32'h00A00293, 1, 0, 0, 8'd2);
        tbl[12] = mk(0, 1, 8'h55, 0, 0, 32'h4, 32'h00A00293, 1, 0, 0, 8'd2);

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Nominal load from the vector table
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            start      = tbl[i].st;
            byte_valid = tbl[i].bv;
            byte_data  = tbl[i].bd;
            #1;
            chk($sformatf("nom%0d.ready", i), 32'(byte_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("nom%0d.busy", i), 32'(busy), 32'(tbl[i].e_rdy));
            chk($sformatf("nom%0d.we", i), 32'(we), 32'(tbl[i].e_we));
            chk($sformatf("nom%0d.waddr", i), waddr, tbl[i].e_a);
            chk($sformatf("nom%0d.wdata", i), wdata, tbl[i].e_d);
            chk($sformatf("nom%0d.done", i), 32'(done), 32'(tbl[i].e_dn));
            chk($sformatf("nom%0d.err", i), 32'(err), 32'(tbl[i].e_er));
            chk($sformatf("nom%0d.hold", i), 32'(cpu_hold), 32'(tbl[i].e_h));
            chk($sformatf("nom%0d.wcount", i), 32'(wcount), 32'(tbl[i].e_wc));
        end
        idle_bus();

        // Bad checksum: both words still written, then ERR
        tx[0] = 32'h00000513;
        tx[1] = 32'h00A00293;
        wq.delete();
        pulse_start();
        stream(2, 8'h00, 0);
        chk("badcs.err", 32'(err), 32'd1);
        chk("badcs.done", 32'(done), 32'd0);
        chk("badcs.hold", 32'(cpu_hold), 32'd1);
        chk("badcs.nwr", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            chk("badcs.a1", wq[1].a, 32'h4);
            chk("badcs.d1", wq[1].d, 32'h00A00293);
        end

        // Illegal lengths 0x00 and 0x41: ERR the cycle after, no writes
        for (int j = 0; j < 2; j++) begin
            logic [7:0] ln;
            ln = (j == 0) ? 8'h00 : 8'h41;
            wq.delete();
            pulse_start();
            send(ln, 0);
            idle_bus();
            chk($sformatf("badlen%0d.err", j), 32'(err), 32'd1);
            chk($sformatf("badlen%0d.busy", j), 32'(busy), 32'd0);
            chk($sformatf("badlen%0d.wcount", j), 32'(wcount), 32'd0);
            chk($sformatf("badlen%0d.nwr", j), 32'(wq.size()), 32'd0);
        end

        // Random gaps plus a start pulse mid-DATA: same writes as nominal
        wq.delete();
        pulse_start();
        send(8'h02, 2);
        for (int k = 0; k < 3; k++) send(tx[0][k*8 +: 8], 2);
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("fc.busy_after_start", 32'(busy), 32'd1);
        send(tx[0][31:24], 2);
        for (int k = 0; k < 4; k++) send(tx[1][k*8 +: 8], 2);
        send(8'h27, 2);
        idle_bus();
        chk("fc.done", 32'(done), 32'd1);
        chk("fc.wcount", 32'(wcount), 32'd2);
        chk("fc.nwr", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            chk("fc.a0", wq[0].a, 32'h0);
            chk("fc.d0", wq[0].d, 32'h00000513);
            chk("fc.a1", wq[1].a, 32'h4);
            chk("fc.d1", wq[1].d, 32'h00A00293);
        end

        // Reset after 6 data bytes, then a clean 1-word load
        pulse_start();
        send(8'h02, 0);
        for (int k = 0; k < 4; k++) send(tx[0][k*8 +: 8], 0);
        for (int k = 0; k < 2; k++) send(tx[1][k*8 +: 8], 0);
        @(negedge clk);
        byte_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        wq.delete();
        tx[0] = 32'hDEADBEEF;
        pulse_start();
        stream(1, 8'h22, 0);
        chk("rst1.done", 32'(done), 32'd1);
        chk("rst1.nwr", 32'(wq.size()), 32'd1);
        if (wq.size() == 1) begin
            chk("rst1.a", wq[0].a, 32'h0);
            chk("rst1.d", wq[0].d, 32'hDEADBEEF);
        end

        // Full-depth reload from DONE, back-to-back bytes
        for (int w = 0; w < 64; w++) tx[w] = {8'(w), 8'(w * 3), ~8'(w), 8'hA5};
        wq.delete();
        pulse_start();
        #1;
        chk("reload.hold_on_len", 32'(cpu_hold), 32'd1);
        chk("reload.ready_on_len", 32'(byte_ready), 32'd1);
        chk("reload.done_cleared", 32'(done), 32'd0);
        stream(64, xor_of(64), 0);
        chk("reload.done", 32'(done), 32'd1);
        chk("reload.hold", 32'(cpu_hold), 32'd0);
        chk("reload.wcount", 32'(wcount), 32'd64);
        chk("reload.nwr", 32'(wq.size()), 32'd64);
        if (wq.size() == 64) begin
            int nbad;
            nbad = 0;
            for (int w = 0; w < 64; w++) begin
                if (wq[w].a !== 32'(w * 4) || wq[w].d !== tx[w]) nbad++;
            end
            chk("reload.words_bad", 32'(nbad), 32'd0);
            chk("reload.last_addr", wq[63].a, 32'hFC);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
